// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 buffered demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned CNT_W  = 16;

  typedef logic [CH_W-1:0] ch_idx_t;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  function automatic ch_idx_t next_ch(input ch_idx_t ch);
    return ch + ch_idx_t'(1);
  endfunction

endpackage

// File: rtl/demux_1_4_buf_if.sv
// Producer/consumer bundle of the demux: one input stream, four output channels.
interface demux_1_4_buf_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0]  In;
  logic              InValid;
  logic              InReady;
  logic              Sel1;
  logic              Sel0;
  logic              Mode;
  logic [WIDTH-1:0]  Out0;
  logic [WIDTH-1:0]  Out1;
  logic [WIDTH-1:0]  Out2;
  logic [WIDTH-1:0]  Out3;
  logic [NUM_CH-1:0] OutValid;
  logic [NUM_CH-1:0] OutReady;
  logic [CNT_W-1:0]  XferCnt;

  // Environment side: drives the input word and the consumer ready flags
  modport master (
    output In, InValid, Sel1, Sel0, Mode, OutReady,
    input  InReady, Out0, Out1, Out2, Out3, OutValid, XferCnt
  );

  modport slave (
    input  In, InValid, Sel1, Sel0, Mode, OutReady,
    output InReady, Out0, Out1, Out2, Out3, OutValid, XferCnt
  );

endinterface

// File: rtl/demux_1_4_buf_slot.sv
// One-entry holding register for a demux channel; drain and reload may
// coincide so a busy channel keeps full throughput.
module demux_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Data changes only on load; a drain clears valid but keeps the word
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux_1_4_buf.sv
// 1-to-4 demux with a one-word buffer per channel, steered by select or
// round-robin; counts accepted words.
module demux_1_4_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  demux_1_4_buf_if.slave   bus
);

  ch_idx_t           target_c;
  ch_idx_t           rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic              in_ready_c;
  logic              accept_c;
  logic [NUM_CH-1:0] load_c;
  logic [NUM_CH-1:0] slot_valid;
  logic [WIDTH-1:0]  slot_data [NUM_CH];
  mode_e             mode_c;

  assign mode_c = mode_e'(bus.Mode);

  // Destination follows the live select; nothing is latched per word
  always_comb begin
    target_c = ch_idx_t'({bus.Sel1, bus.Sel0});
    if (mode_c == MODE_RR) begin
      target_c = rr_ptr_q;
    end
  end

  assign in_ready_c  = ~slot_valid[target_c] | bus.OutReady[target_c];
  assign accept_c    = bus.InValid & in_ready_c & ~Rst;
  assign bus.InReady = in_ready_c;

  always_comb begin
    load_c           = '0;
    load_c[target_c] = accept_c;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    xfer_cnt_d = xfer_cnt_q;
    if (accept_c) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
      if (mode_c == MODE_RR) begin
        rr_ptr_d = next_ch(rr_ptr_q);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rr_ptr_q   <= '0;
      xfer_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk_i   (Clk),
      .rst_i   (Rst),
      .load_i  (load_c[i]),
      .data_i  (bus.In),
      .ready_i (bus.OutReady[i]),
      .data_o  (slot_data[i]),
      .valid_o (slot_valid[i])
    );
  end

  assign bus.Out0     = slot_data[0];
  assign bus.Out1     = slot_data[1];
  assign bus.Out2     = slot_data[2];
  assign bus.Out3     = slot_data[3];
  assign bus.OutValid = slot_valid;
  assign bus.XferCnt  = xfer_cnt_q;

endmodule

// File: doc/demux_1_4_buf.md
DEMUX_1_4_BUF -- requirements
Module: demux_1_4_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width of the input and each output channel.
REQ-002 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Rst  input  1  reset; synchronous, active-high.
REQ-004 In  input  WIDTH  input data word.
REQ-005 InValid  input  1  input word present.
REQ-006 InReady  output  1  block accepts the word this cycle.
REQ-007 Sel1, Sel0  input  1 each  destination channel {Sel1,Sel0}, used when Mode=0.
REQ-008 Mode  input  1  0 = steer by select; 1 = round-robin distribution.
REQ-009 Out0..Out3  output  WIDTH each  channel data.
REQ-010 OutValid  output  4  per-channel word-present flag, bit i for channel i.
REQ-011 OutReady  input  4  per-channel consumer ready, bit i for channel i.
REQ-012 XferCnt  output  16  count of accepted input words.

Function
REQ-013 Target channel T SHALL be RrPtr when Mode=1, else {Sel1,Sel0}; evaluated combinationally each cycle.
REQ-014 Each channel SHALL hold exactly one word in a holding register.
REQ-015 InReady SHALL equal (~OutValid[T] | OutReady[T]) and SHALL NOT depend on InValid.
REQ-016 Accept = InValid & InReady; on accept, Out<T> SHALL load In and OutValid[T] SHALL be 1 the next cycle (latency 1 clock).
REQ-017 A channel drains when OutValid[i] & OutReady[i]; OutValid[i] SHALL clear next cycle unless the same channel is reloaded that cycle, in which case it SHALL stay 1 with new data (full-throughput, no bubble).
REQ-018 While OutValid[i]=1 and OutReady[i]=0, Out<i> and OutValid[i] SHALL hold stable.
REQ-019 Out<i> SHALL NOT change except on an accept targeting channel i; data is not cleared on drain.
REQ-020 Channels SHALL drain independently; a stalled channel SHALL NOT block accepts targeting other channels.
REQ-021 RrPtr (2 bits) SHALL advance by 1 on each accept while Mode=1, wrapping 3 -> 0; it SHALL hold while Mode=0 or when no accept occurs.
REQ-022 A Mode change SHALL take effect the same cycle; RrPtr SHALL NOT be reset by a Mode change.
REQ-023 In Mode=0, Sel may change while a word is stalled; T follows the current Sel (no destination latching).
REQ-024 XferCnt SHALL increment by 1 on each accept and wrap 0xFFFF -> 0x0000.

Reset
REQ-025 While Rst=1 at a clock edge: OutValid=0, Out0..Out3=0, RrPtr=0, XferCnt=0.
REQ-026 InReady SHALL be 1 during and after reset (all channels empty); no accept SHALL be recorded during a cycle where Rst=1.
REQ-027 Reset mid-transfer SHALL discard all held words without them being presented.

Structure
REQ-028 Shared package demux_pkg SHALL define NUM_CH=4, the 2-bit channel-index type and the Mode encodings.
REQ-029 One sub-module demux_slot (one-entry holding register with load/drain/valid logic, WIDTH-parametrized) SHALL be instantiated four times.
REQ-030 Top level SHALL contain only target selection, InReady generation, RrPtr and XferCnt.

Verification
REQ-031 Reset: assert Rst with OutValid previously 4'b1111 -> OutValid=0, all Out=0, XferCnt=0, InReady=1.
REQ-032 Select steering: Mode=0, Sel=2'b10, In=0xA5, InValid=1 one cycle, OutReady=0 -> next cycle OutValid=4'b0100, Out2=0xA5; repeat to channel 2 -> InReady=0, Out2 stays 0xA5.
REQ-033 Round-robin: Mode=1, OutReady=4'b1111, send 0x01..0x06 back-to-back -> channels 0,1,2,3,0,1 receive in order, InReady continuously 1, XferCnt=6.
REQ-034 Stall isolation: Mode=0, channel 1 full with OutReady[1]=0; send 0x33 to channel 3 -> accepted, Out3=0x33; then raise OutReady[1] while sending 0x44 to channel 1 -> same-cycle drain+reload, OutValid[1] stays 1, Out1=0x44.
REQ-035 Wrap: preload XferCnt to 0xFFFF via 65535 accepts, one more accept -> XferCnt=0x0000; RrPtr after accepts from 3 -> 0.
REQ-036 Mid-operation reset: channels 0 and 3 holding 0x11/0x22 stalled, pulse Rst one cycle -> OutValid=0, RrPtr=0, next accept in Mode=1 lands in channel 0.
